prvp_spi_slave_cmd_fsm: RTL and testbench
=========================================

Name: prvp_spi_slave_cmd_fsm

Overview:
- Command front-end of the SPI slave. Runs on the SPI clock domain.
- Deserialises command and data bytes from the pads and decodes register-write and register-read commands.
- Drives the write/read interface of the slave config register file.
- Serialises read data back to the pads, honouring the register file's en_qpi and dummy_cycles outputs.

Parameters:
- REG_SIZE, 8, width of config register data. Fixed at 8; the byte framing below relies on it.

Ports:
- sclk  in  1  SPI clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  chip select, active low, already synchronous to sclk.
- sdi  in  4  pad input data; only sdi[0] is used in SPI mode.
- en_qpi  in  1  quad mode enable, from the register file.
- dummy_cycles  in  8  read dummy-cycle count, from the register file.
- rd_data  in  REG_SIZE  register read data; combinational from rd_addr.
- wr_data  out  REG_SIZE  register write data.
- wr_addr  out  2  register write address.
- wr_data_valid  out  1  single-cycle register write strobe.
- rd_addr  out  2  register read address.
- sdo  out  4  pad output data; only sdo[0] is driven in SPI mode.
- sdo_oe  out  1  pad output enable.
- err_cnt  out  8  invalid-opcode count (see Optional Feature).

Behaviour:
- Reset: state=IDLE; wr_data=0, wr_addr=0, wr_data_valid=0, rd_addr=0, sdo=0, sdo_oe=0, err_cnt=0.
- Mode latch: en_qpi is latched into a mode flag on the IDLE->CMD transition and held for the whole transaction.
  - A write to reg0 takes effect at the next transaction.
- Bits per cycle: SPI = 1 (sdi[0]), MSB first. QPI = 4 (sdi[3:0]), high nibble first.
- One byte = 8 cycles in SPI, 2 cycles in QPI. A byte counter tracks progress.
- Command byte format: [7:4] opcode, [3:2] ignored, [1:0] register address. Opcode 0x1 = WRITE, 0x2 = READ, any other value = invalid.
- cs_n=1 in any state: next state is IDLE, counters clear, sdo_oe=0. A partial byte is discarded and never produces a write.
- IDLE: on cs_n=0, sample the first command bit/nibble in that same cycle and go to CMD.
- CMD: on the edge that completes the command byte:
  - WRITE -> WDATA; wr_addr <= addr.
  - READ -> DUMMY; rd_addr <= addr; dummy counter <= dummy_cycles.
  - Invalid -> IGNORE.
- WDATA: on the edge that completes the data byte, wr_data <= byte and wr_data_valid <= 1 for exactly one cycle. Then go to IGNORE.
  - Exactly one write per transaction; further clocks with cs_n=0 are ignored.
- DUMMY: the counter decrements each cycle. When it is 0 (including dummy_cycles=0 on entry), go to LOAD.
  - N dummy cycles occupy exactly N cycles; 255 is legal.
- LOAD: one cycle, sdo_oe=0. The shift register <= rd_data, since rd_addr is stable by then. Go to RDATA.
- RDATA: sdo_oe=1.
  - SPI: sdo[0] = shift[7]; sdo[3:1] = 0.
  - QPI: sdo = shift[7:4].
  - The register shifts by 1 or 4 each cycle. After 8 (SPI) or 2 (QPI) cycles go to IGNORE with sdo_oe=0.
- IGNORE: hold until cs_n=1.
- Reset asserted mid-transaction: all outputs return to reset values on the next edge. A pending wr_data_valid is suppressed.
- wr_data and wr_addr hold their last values between writes.

Optional Feature:
- Macro: PRVP_SPI_SLAVE_CMD_ERR_CNT_EN.
- Defined: err_cnt increments by one on each invalid opcode (CMD->IGNORE). It saturates at 255 and clears only on rst.
- Undefined: the counter logic is absent and err_cnt is tied to 0.

Test Plan:
- SPI write: cs_n=0; shift 0x11 then 0xA5 on sdi[0] -> wr_data_valid high for one cycle right after the 16th sampled bit; wr_addr=1, wr_data=0xA5; no further strobe while cs_n stays low.
- QPI write: en_qpi=1; nibbles 1,2,3,C -> one strobe after the 4th sampled nibble with wr_addr=2, wr_data=0x3C. Toggling en_qpi to 0 mid-transaction does not change the framing.
- SPI read: dummy_cycles=4, rd_data model returns 0x96 for addr 3; command 0x23 -> 4 DUMMY cycles, 1 LOAD cycle, then sdo_oe=1 for 8 cycles with sdo[0] = 1,0,0,1,0,1,1,0.
- QPI read with dummy_cycles=0: command 0x20, reg0 model = 0x5A -> LOAD immediately after the command, sdo = 0x5 then 0xA, then sdo_oe=0.
- Abort and errors: raise cs_n after 5 data bits of a WRITE -> no strobe, next transaction decodes cleanly. Send opcode 0x7 three times -> err_cnt=3 with the macro defined, 0 without.
- Reset mid-read: assert rst during RDATA -> next edge sdo_oe=0, rd_addr=0, state IDLE.

Source files
------------

// File: rtl/prvp_spi_slave_cmd_fsm_if.sv
// Pad and register-file signal bundle for the SPI slave command front-end.
// The slave modport is the front-end's view; master is the pads/register-file side.
interface prvp_spi_slave_cmd_fsm_if #(
    parameter int REG_SIZE = 8
);
    logic                cs_n;
    logic [3:0]          sdi;
    logic                en_qpi;
    logic [7:0]          dummy_cycles;
    logic [REG_SIZE-1:0] rd_data;
    logic [REG_SIZE-1:0] wr_data;
    logic [1:0]          wr_addr;
    logic                wr_data_valid;
    logic [1:0]          rd_addr;
    logic [3:0]          sdo;
    logic                sdo_oe;
    logic [7:0]          err_cnt;

    modport slave (
        input  cs_n, sdi, en_qpi, dummy_cycles, rd_data,
        output wr_data, wr_addr, wr_data_valid, rd_addr, sdo, sdo_oe, err_cnt
    );

    modport master (
        output cs_n, sdi, en_qpi, dummy_cycles, rd_data,
        input  wr_data, wr_addr, wr_data_valid, rd_addr, sdo, sdo_oe, err_cnt
    );
endinterface

// File: rtl/prvp_spi_slave_cmd_fsm.sv
// SPI/QPI slave command front-end: decodes register write/read commands on sclk.
// Optional invalid-opcode counter enabled by defining PRVP_SPI_SLAVE_CMD_ERR_CNT_EN.
module prvp_spi_slave_cmd_fsm #(
    parameter int REG_SIZE = 8
) (
    input  logic                    sclk,
    input  logic                    rst,
    prvp_spi_slave_cmd_fsm_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, DUMMY, LOAD, RDATA, IGNORE} state_e;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [6:0]          shift_in_q, shift_in_d;
    logic [REG_SIZE-1:0] shift_out_q, shift_out_d;
    logic [7:0]          dummy_q, dummy_d;
    logic [REG_SIZE-1:0] wr_data_q, wr_data_d;
    logic [1:0]          wr_addr_q, wr_addr_d;
    logic                wr_valid_q, wr_valid_d;
    logic [1:0]          rd_addr_q, rd_addr_d;

    logic                qpi;
    logic [7:0]          byte_in;
    logic                byte_done;
    logic [3:0]          opcode;

    // The mode flag is not latched until the first IDLE sample, so that cycle follows en_qpi directly.
    assign qpi       = (state_q == IDLE) ? bus.en_qpi : mode_q;
    assign byte_in   = qpi ? {shift_in_q[3:0], bus.sdi} : {shift_in_q, bus.sdi[0]};
    assign byte_done = (bit_cnt_q == (qpi ? 3'd1 : 3'd7));
    assign opcode    = byte_in[7:4];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            dummy_q     <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            dummy_q     <= dummy_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_valid_q  <= wr_valid_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = CMD;
                CMD: begin
                    if (byte_done) begin
                        case (opcode)
                            OP_WRITE: state_d = WDATA;
                            OP_READ:  state_d = (bus.dummy_cycles == 8'd0) ? LOAD : DUMMY;
                            default:  state_d = IGNORE;
                        endcase
                    end
                end
                WDATA:  if (byte_done) state_d = IGNORE;
                DUMMY:  if (dummy_q == 8'd1) state_d = LOAD;
                LOAD:   state_d = RDATA;
                RDATA:  if (byte_done) state_d = IGNORE;
                IGNORE: state_d = IGNORE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        mode_d      = mode_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        dummy_d     = dummy_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        wr_valid_d  = 1'b0;
        rd_addr_d   = rd_addr_q;
        if (bus.cs_n) begin
            bit_cnt_d = '0;
            dummy_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    mode_d     = bus.en_qpi;
                    shift_in_d = byte_in[6:0];
                    bit_cnt_d  = 3'd1;
                end
                CMD, WDATA: begin
                    shift_in_d = byte_in[6:0];
                    bit_cnt_d  = byte_done ? 3'd0 : bit_cnt_q + 3'd1;
                    if (byte_done && state_q == WDATA) begin
                        wr_data_d  = byte_in;
                        wr_valid_d = 1'b1;
                    end else if (byte_done && opcode == OP_WRITE) begin
                        wr_addr_d = byte_in[1:0];
                    end else if (byte_done && opcode == OP_READ) begin
                        rd_addr_d = byte_in[1:0];
                        dummy_d   = bus.dummy_cycles;
                    end
                end
                DUMMY: dummy_d = dummy_q - 8'd1;
                LOAD: begin
                    shift_out_d = bus.rd_data;
                    bit_cnt_d   = '0;
                end
                RDATA: begin
                    shift_out_d = qpi ? {shift_out_q[REG_SIZE-5:0], 4'b0000}
                                      : {shift_out_q[REG_SIZE-2:0], 1'b0};
                    bit_cnt_d   = byte_done ? 3'd0 : bit_cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.sdo_oe = 1'b0;
        bus.sdo    = 4'b0000;
        if (state_q == RDATA && !bus.cs_n) begin
            bus.sdo_oe = 1'b1;
            bus.sdo    = qpi ? shift_out_q[REG_SIZE-1 -: 4] : {3'b000, shift_out_q[REG_SIZE-1]};
        end
    end

    assign bus.wr_data       = wr_data_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_data_valid = wr_valid_q;
    assign bus.rd_addr       = rd_addr_q;

`ifdef PRVP_SPI_SLAVE_CMD_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       err_inc;

    assign err_inc = !bus.cs_n && state_q == CMD && byte_done
                     && opcode != OP_WRITE && opcode != OP_READ;

    always_ff @(posedge sclk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_prvp_spi_slave_cmd_fsm.sv
// Self-checking bench for prvp_spi_slave_cmd_fsm: transaction-position model plus directed literals.
module tb_prvp_spi_slave_cmd_fsm;

`ifdef PRVP_SPI_SLAVE_CMD_ERR_CNT_EN
    localparam int ERR_INC = 1;
`else
    localparam int ERR_INC = 0;
`endif

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] rf [4];
    logic [3:0] sdo_q [$];
    int         strobes = 0;

    prvp_spi_slave_cmd_fsm_if #(.REG_SIZE(8)) bus ();

    prvp_spi_slave_cmd_fsm #(.REG_SIZE(8)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 sclk = ~sclk;

    assign bus.rd_data = rf[bus.rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: outputs follow from how many cs_n-low cycles the transaction has consumed.
    int         n = 0;
    int         cpb = 8;
    int         m_dly = 0;
    logic       m_qpi = 1'b0;
    logic [7:0] acc = '0;
    logic [7:0] cmd = '0;
    logic       e_valid = 1'b0;
    logic [7:0] e_wd = '0;
    logic [1:0] e_wa = '0;
    logic [1:0] e_ra = '0;
    int         e_err = 0;

    always begin
        logic       e_oe;
        logic [3:0] e_sdo;
        logic [7:0] sh;
        int         j;
        @(posedge sclk);
        if (rst) begin
            n = 0; e_valid = 0; e_wd = '0; e_wa = '0; e_ra = '0; e_err = 0; cmd = '0;
        end else if (bus.cs_n) begin
            n = 0; e_valid = 0;
        end else begin
            n++;
            e_valid = 0;
            if (n == 1) m_qpi = bus.en_qpi;
            cpb = m_qpi ? 2 : 8;
            acc = m_qpi ? {acc[3:0], bus.sdi} : {acc[6:0], bus.sdi[0]};
            if (n == cpb) begin
                cmd = acc;
                case (cmd[7:4])
                    4'h1: e_wa = cmd[1:0];
                    4'h2: begin
                        e_ra  = cmd[1:0];
                        m_dly = int'(bus.dummy_cycles);
                    end
                    default: if (ERR_INC == 1 && e_err < 255) e_err++;
                endcase
            end
            if (n == 2 * cpb && cmd[7:4] == 4'h1) begin
                e_valid = 1;
                e_wd    = acc;
            end
        end
        #1;
        e_oe  = (n >= cpb + m_dly + 1) && (n <= 2 * cpb + m_dly) && (cmd[7:4] == 4'h2);
        e_sdo = 4'h0;
        if (e_oe) begin
            j     = n - (cpb + m_dly + 1);
            sh    = rf[e_ra] << (j * (m_qpi ? 4 : 1));
            e_sdo = m_qpi ? sh[7:4] : {3'b000, sh[7]};
        end
        check("wr_data_valid", bus.wr_data_valid, e_valid);
        check("wr_data", bus.wr_data, e_wd);
        check("wr_addr", bus.wr_addr, e_wa);
        check("rd_addr", bus.rd_addr, e_ra);
        check("sdo_oe", bus.sdo_oe, e_oe);
        check("sdo", bus.sdo, e_sdo);
        check("err_cnt", bus.err_cnt, e_err);
        if (bus.sdo_oe) sdo_q.push_back(bus.sdo);
        if (bus.wr_data_valid) strobes++;
    end

    task automatic cyc(input logic cs, input logic [3:0] d);
        @(negedge sclk);
        bus.cs_n = cs;
        bus.sdi  = d;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) cyc(1'b0, {3'b000, b[i]});
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        cyc(1'b0, b[7:4]);
        cyc(1'b0, b[3:0]);
    endtask

    task automatic gap(input int k);
        repeat (k) cyc(1'b1, 4'h0);
    endtask

    task automatic hold(input int k, input logic [3:0] d);
        repeat (k) cyc(1'b0, d);
    endtask

    task automatic clear_cap;
        sdo_q.delete();
        strobes = 0;
    endtask

    initial begin
        logic [7:0] r;
        rf[0] = 8'h5A; rf[1] = 8'h00; rf[2] = 8'h00; rf[3] = 8'h96;
        bus.cs_n = 1'b1; bus.sdi = 4'h0; bus.en_qpi = 1'b0; bus.dummy_cycles = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge sclk);
        check("reset_sdo_oe", bus.sdo_oe, 1'b0);
        check("reset_wr_valid", bus.wr_data_valid, 1'b0);
        check("reset_wr_addr", bus.wr_addr, 2'd0);
        check("reset_rd_addr", bus.rd_addr, 2'd0);
        check("reset_err_cnt", bus.err_cnt, 8'd0);
        rst = 1'b0;
        gap(2);

        // SPI write 0x11, 0xA5 with trailing clocks
        clear_cap();
        spi_byte(8'h11); spi_byte(8'hA5); hold(6, 4'hF); gap(2);
        check("spi_wr_strobes", strobes, 1);
        check("spi_wr_addr", bus.wr_addr, 2'd1);
        check("spi_wr_data", bus.wr_data, 8'hA5);

        // QPI write; en_qpi dropped before the last nibble
        bus.en_qpi = 1'b1;
        gap(1);
        clear_cap();
        qpi_byte(8'h12); cyc(1'b0, 4'h3); bus.en_qpi = 1'b0; cyc(1'b0, 4'hC);
        hold(4, 4'h0); gap(2);
        check("qpi_wr_strobes", strobes, 1);
        check("qpi_wr_addr", bus.wr_addr, 2'd2);
        check("qpi_wr_data", bus.wr_data, 8'h3C);

        // SPI read of reg3 with 4 dummy cycles
        bus.dummy_cycles = 8'd4;
        gap(1);
        clear_cap();
        spi_byte(8'h23); hold(16, 4'h0); gap(2);
        check("spi_rd_len", sdo_q.size(), 8);
        r = '0;
        foreach (sdo_q[i]) r = {r[6:0], sdo_q[i][0]};
        check("spi_rd_bits", r, 8'h96);

        // QPI read of reg0 with no dummy cycles
        bus.en_qpi = 1'b1; bus.dummy_cycles = 8'd0;
        gap(1);
        clear_cap();
        qpi_byte(8'h20); hold(6, 4'h0); gap(2);
        bus.en_qpi = 1'b0;
        check("qpi_rd_len", sdo_q.size(), 2);
        if (sdo_q.size() == 2) check("qpi_rd_nibbles", {sdo_q[0], sdo_q[1]}, 8'h5A);

        // Abort a write after 5 data bits, then a clean write
        gap(1);
        clear_cap();
        spi_byte(8'h11); hold(5, 4'h1); gap(2);
        check("abort_strobes", strobes, 0);
        spi_byte(8'h12); spi_byte(8'hC3); hold(2, 4'h0); gap(2);
        check("post_abort_strobes", strobes, 1);
        check("post_abort_addr", bus.wr_addr, 2'd2);
        check("post_abort_data", bus.wr_data, 8'hC3);

        // Three invalid opcodes
        for (int t = 0; t < 3; t++) begin
            spi_byte(8'h70); hold(3, 4'h0); gap(2);
        end
        check("err_cnt_after_3", bus.err_cnt, 8'(3 * ERR_INC));

        // Reset during RDATA
        spi_byte(8'h23); hold(4, 4'h0);
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        check("rst_sdo_oe", bus.sdo_oe, 1'b0);
        check("rst_rd_addr", bus.rd_addr, 2'd0);
        check("rst_err_cnt", bus.err_cnt, 8'd0);
        rst = 1'b0;
        bus.cs_n = 1'b1;
        gap(2);
        clear_cap();
        spi_byte(8'h13); spi_byte(8'h5E); hold(2, 4'h0); gap(2);
        check("post_rst_strobes", strobes, 1);
        check("post_rst_addr", bus.wr_addr, 2'd3);
        check("post_rst_data", bus.wr_data, 8'h5E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
